// File: rtl/m68k_periph_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : m68k_periph_bridge_if
// Description : Bus bundle between the 68000 CPU side, the peripheral bridge
//               and the on-chip peripheral devices.
//               slave  : seen by the bridge (CPU strobes/address/data and the
//                        device ack/read data in; DTACK/BERR/read data and the
//                        device strobes/address/write data out).
//               master : seen by the CPU model plus devices (mirror of slave).
//               NDEV must match the NDEV of the bridge it connects to.
// Revision    : 1.0 - initial release
// ============================================================================
interface m68k_periph_bridge_if #(
  parameter int NDEV = 4
);
  // CPU side
  logic            cpu_as_n;
  logic            cpu_uds_n;
  logic            cpu_lds_n;
  logic            cpu_rw;
  logic [23:1]     cpu_addr;
  logic [15:0]     cpu_data_out;
  logic [15:0]     cpu_data_in;
  logic            cpu_dtack_n;
  logic            cpu_berr_n;
  // Peripheral side
  logic [7:0]      dev_addr;
  logic [15:0]     dev_data_write;
  logic            dev_rw;
  logic [NDEV-1:0] dev_uds;
  logic [NDEV-1:0] dev_lds;
  logic            dev_ack;
  logic [15:0]     dev_data_read;

  modport slave (
    input  cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_addr, cpu_data_out,
    output cpu_data_in, cpu_dtack_n, cpu_berr_n,
    output dev_addr, dev_data_write, dev_rw, dev_uds, dev_lds,
    input  dev_ack, dev_data_read
  );

  modport master (
    output cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_addr, cpu_data_out,
    input  cpu_data_in, cpu_dtack_n, cpu_berr_n,
    input  dev_addr, dev_data_write, dev_rw, dev_uds, dev_lds,
    output dev_ack, dev_data_read
  );
endinterface
`default_nettype wire

// File: rtl/m68k_periph_bridge.sv
`default_nettype none
// ============================================================================
// Module      : m68k_periph_bridge
// Description : Bridges the asynchronous 68000 bus (AS/UDS/LDS/DTACK) onto the
//               synchronous peripheral bus. Decodes the BASE window, issues a
//               one-cycle per-slot byte strobe, waits for the device ack and
//               answers with DTACK, or BERR on timeout / unmapped slot.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset
//               bus   - m68k_periph_bridge_if.slave (CPU and device buses)
// Parameters  : NDEV    - device slots (slot = cpu_addr[11:8]), 1..16
//               BASE    - window matched against cpu_addr[23:16]
//               TIMEOUT - max WAIT cycles before BERR, >= 2
// Revision    : 1.0 - initial release
// ============================================================================
module m68k_periph_bridge #(
  parameter int         NDEV    = 4,
  parameter logic [7:0] BASE    = 8'hFF,
  parameter int         TIMEOUT = 16
) (
  input  wire logic               clk,
  input  wire logic               reset,
  m68k_periph_bridge_if.slave     bus
);

  localparam int c_CW = $clog2(TIMEOUT);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);
  localparam logic [NDEV-1:0] c_ONE = NDEV'(1);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_STROBE  = 3'd1;
  localparam logic [2:0] c_WAIT    = 3'd2;
  localparam logic [2:0] c_DONE    = 3'd3;
  localparam logic [2:0] c_ERR     = 3'd4;
  localparam logic [2:0] c_RELEASE = 3'd5;

  // 2-FF synchronisers for the asynchronous strobes (negated = 1)
  logic r_as_meta, r_as_s;
  logic r_uds_meta, r_uds_s;
  logic r_lds_meta, r_lds_s;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic            r_as_seen_high;
  logic [3:0]      r_slot;
  logic            r_ube;
  logic            r_lbe;
  logic [c_CW-1:0] r_cnt;
  logic [7:0]      r_dev_addr;
  logic [15:0]     r_dev_data_write;
  logic            r_dev_rw;
  logic [15:0]     r_cpu_data_in;
  logic            r_dtack_n;
  logic            r_berr_n;
  logic [NDEV-1:0] w_uds;
  logic [NDEV-1:0] w_lds;

  logic [3:0] w_slot;
  logic       w_hit;
  logic       w_unmapped;
  logic       w_timeout;
  logic       w_unused_addr;

  assign w_slot     = bus.cpu_addr[11:8];
  // A new cycle starts only after AS has been seen negated, so a held-low AS
  // (read-modify-write) cannot re-trigger the FSM.
  assign w_hit      = r_as_seen_high && !r_as_s && (!r_uds_s || !r_lds_s) &&
                      (bus.cpu_addr[23:16] == BASE);
  assign w_unmapped = ({1'b0, w_slot} >= 5'(NDEV));
  assign w_timeout  = (r_cnt == c_CNT_LAST);
  assign w_unused_addr = &{1'b0, bus.cpu_addr[15:12]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:    if (w_hit) w_next = w_unmapped ? c_ERR : c_STROBE;
      c_STROBE:  w_next = c_WAIT;
      // Ack beats a simultaneous timeout
      c_WAIT:    if (bus.dev_ack) w_next = c_DONE;
                 else if (w_timeout) w_next = c_ERR;
      c_DONE:    if (r_as_s) w_next = c_RELEASE;
      c_ERR:     if (r_as_s) w_next = c_RELEASE;
      c_RELEASE: w_next = c_IDLE;
      default:   w_next = c_IDLE;
    endcase
  end

  // Strobes are decoded from registered state so they are clean one-cycle pulses
  always_comb begin
    w_uds = '0;
    w_lds = '0;
    if (r_state == c_STROBE) begin
      if (r_ube) w_uds = c_ONE << r_slot;
      if (r_lbe) w_lds = c_ONE << r_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_as_meta        <= 1'b1;
      r_as_s           <= 1'b1;
      r_uds_meta       <= 1'b1;
      r_uds_s          <= 1'b1;
      r_lds_meta       <= 1'b1;
      r_lds_s          <= 1'b1;
      r_state          <= c_IDLE;
      r_as_seen_high   <= 1'b0;
      r_slot           <= 4'd0;
      r_ube            <= 1'b0;
      r_lbe            <= 1'b0;
      r_cnt            <= '0;
      r_dev_addr       <= 8'h00;
      r_dev_data_write <= 16'h0000;
      r_dev_rw         <= 1'b1;
      r_cpu_data_in    <= 16'h0000;
      r_dtack_n        <= 1'b1;
      r_berr_n         <= 1'b1;
    end else begin
      r_as_meta  <= bus.cpu_as_n;
      r_as_s     <= r_as_meta;
      r_uds_meta <= bus.cpu_uds_n;
      r_uds_s    <= r_uds_meta;
      r_lds_meta <= bus.cpu_lds_n;
      r_lds_s    <= r_lds_meta;

      r_state   <= w_next;
      r_dtack_n <= (w_next != c_DONE);
      r_berr_n  <= (w_next != c_ERR);

      if ((r_state == c_IDLE) && w_hit) r_as_seen_high <= 1'b0;
      else if (r_as_s)                  r_as_seen_high <= 1'b1;

      case (r_state)
        c_IDLE: begin
          if (w_hit) begin
            r_slot           <= w_slot;
            r_ube            <= ~r_uds_s;
            r_lbe            <= ~r_lds_s;
            r_dev_addr       <= {bus.cpu_addr[7:1], 1'b0};
            r_dev_rw         <= bus.cpu_rw;
            r_dev_data_write <= bus.cpu_data_out;
          end
        end
        c_STROBE: r_cnt <= '0;
        c_WAIT: begin
          if (bus.dev_ack) begin
            if (r_dev_rw) r_cpu_data_in <= bus.dev_data_read;
          end else if (!w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_data_in    = r_cpu_data_in;
  assign bus.cpu_dtack_n    = r_dtack_n;
  assign bus.cpu_berr_n     = r_berr_n;
  assign bus.dev_addr       = r_dev_addr;
  assign bus.dev_data_write = r_dev_data_write;
  assign bus.dev_rw         = r_dev_rw;
  assign bus.dev_uds        = w_uds;
  assign bus.dev_lds        = w_lds;

endmodule
`default_nettype wire

// File: tb/tb_m68k_periph_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_m68k_periph_bridge
// Description : Directed self-checking bench for m68k_periph_bridge
//               (NDEV=4, BASE=8'hFF, TIMEOUT=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m68k_periph_bridge;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  m68k_periph_bridge_if #(.NDEV(4)) bus ();

  m68k_periph_bridge #(.NDEV(4), .BASE(8'hFF), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Outputs are sampled and inputs driven 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic [23:0] ba, input logic rw,
                           input logic uds_n, input logic lds_n,
                           input logic [15:0] d);
    bus.cpu_addr     = ba[23:1];
    bus.cpu_rw       = rw;
    bus.cpu_data_out = d;
    bus.cpu_uds_n    = uds_n;
    bus.cpu_lds_n    = lds_n;
    bus.cpu_as_n     = 1'b0;
  endtask

  task automatic cpu_release();
    bus.cpu_as_n  = 1'b1;
    bus.cpu_uds_n = 1'b1;
    bus.cpu_lds_n = 1'b1;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.cpu_as_n     = 1'b1;
    bus.cpu_uds_n    = 1'b1;
    bus.cpu_lds_n    = 1'b1;
    bus.cpu_rw       = 1'b1;
    bus.cpu_addr     = '0;
    bus.cpu_data_out = 16'h0000;
    bus.dev_ack      = 1'b0;
    bus.dev_data_read = 16'h0000;
    tick(); tick(); tick();
    checks++; if (bus.cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL reset_dtack_n: got %b expected 1", bus.cpu_dtack_n); end
    checks++; if (bus.cpu_berr_n !== 1'b1) begin errors++; $display("FAIL reset_berr_n: got %b expected 1", bus.cpu_berr_n); end
    checks++; if (bus.cpu_data_in !== 16'h0000) begin errors++; $display("FAIL reset_data_in: got %h expected 0000", bus.cpu_data_in); end
    checks++; if (bus.dev_uds !== 4'b0000 || bus.dev_lds !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got uds=%b lds=%b expected 0000/0000", bus.dev_uds, bus.dev_lds); end
    checks++; if (bus.dev_rw !== 1'b1) begin errors++; $display("FAIL reset_dev_rw: got %b expected 1", bus.dev_rw); end
    checks++; if (bus.dev_addr !== 8'h00 || bus.dev_data_write !== 16'h0000) begin errors++; $display("FAIL reset_dev_addr_data: got %h/%h expected 00/0000", bus.dev_addr, bus.dev_data_write); end
    reset = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_word_write();
    cpu_drive(24'hFF0100, 1'b0, 1'b0, 1'b0, 16'hA55A);
    tick(); tick(); tick(); // c1
    checks++; if (bus.dev_uds !== 4'b0010 || bus.dev_lds !== 4'b0010) begin errors++; $display("FAIL write_strobe_c1: got uds=%b lds=%b expected 0010/0010", bus.dev_uds, bus.dev_lds); end
    checks++; if (bus.dev_data_write !== 16'hA55A) begin errors++; $display("FAIL write_data: got %h expected a55a", bus.dev_data_write); end
    checks++; if (bus.dev_rw !== 1'b0 || bus.dev_addr !== 8'h00) begin errors++; $display("FAIL write_rw_addr: got rw=%b addr=%h expected 0/00", bus.dev_rw, bus.dev_addr); end
    tick(); // c2
    checks++; if (bus.dev_uds !== 4'b0000 || bus.dev_lds !== 4'b0000) begin errors++; $display("FAIL write_strobe_c2: got uds=%b lds=%b expected 0000/0000", bus.dev_uds, bus.dev_lds); end
    checks++; if (bus.cpu_dtack_n !== 1'b1 || bus.dev_data_write !== 16'hA55A) begin errors++; $display("FAIL write_c2_hold: got dtack_n=%b data=%h expected 1/a55a", bus.cpu_dtack_n, bus.dev_data_write); end
    bus.dev_ack = 1'b1;
    tick(); // c3
    bus.dev_ack = 1'b0;
    checks++; if (bus.cpu_dtack_n !== 1'b0 || bus.cpu_berr_n !== 1'b1) begin errors++; $display("FAIL write_dtack_c3: got dtack_n=%b berr_n=%b expected 0/1", bus.cpu_dtack_n, bus.cpu_berr_n); end
    cpu_release();
    tick(); tick(); // as_s just rose
    checks++; if (bus.cpu_dtack_n !== 1'b0) begin errors++; $display("FAIL write_dtack_hold: got %b expected 0", bus.cpu_dtack_n); end
    tick();
    checks++; if (bus.cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL write_dtack_release: got %b expected 1", bus.cpu_dtack_n); end
    tick(); tick();
  endtask

  task automatic test_byte_read();
    bit ok;
    cpu_drive(24'hFF0000, 1'b1, 1'b0, 1'b1, 16'h0000);
    tick(); tick(); tick(); // c1
    checks++; if (bus.dev_uds !== 4'b0001 || bus.dev_lds !== 4'b0000 || bus.dev_rw !== 1'b1) begin errors++; $display("FAIL read_strobe_c1: got uds=%b lds=%b rw=%b expected 0001/0000/1", bus.dev_uds, bus.dev_lds, bus.dev_rw); end
    tick(); // c2
    bus.dev_ack = 1'b1;
    bus.dev_data_read = 16'h3C00;
    tick(); // c3
    bus.dev_ack = 1'b0;
    bus.dev_data_read = 16'h0000;
    checks++; if (bus.cpu_dtack_n !== 1'b0 || bus.cpu_data_in !== 16'h3C00) begin errors++; $display("FAIL read_data_c3: got dtack_n=%b data=%h expected 0/3c00", bus.cpu_dtack_n, bus.cpu_data_in); end
    checks++; if (bus.dev_lds !== 4'b0000) begin errors++; $display("FAIL read_lds_c3: got %b expected 0000", bus.dev_lds); end
    cpu_release();
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (bus.cpu_dtack_n === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok || bus.cpu_data_in !== 16'h3C00) begin errors++; $display("FAIL read_release: got released=%b data=%h expected 1/3c00", ok, bus.cpu_data_in); end
    tick(); tick();
  endtask

  task automatic test_timeout();
    int early;
    bit ok;
    cpu_drive(24'hFF0200, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick(); tick(); tick(); // c1
    checks++; if (bus.dev_uds !== 4'b0100 || bus.dev_lds !== 4'b0100) begin errors++; $display("FAIL timeout_strobe: got uds=%b lds=%b expected 0100/0100", bus.dev_uds, bus.dev_lds); end
    tick(); // c2
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (bus.cpu_berr_n !== 1'b1 || bus.cpu_dtack_n !== 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL timeout_early: got %0d bad cycles expected 0", early); end
    tick(); // c2+16
    checks++; if (bus.cpu_berr_n !== 1'b0 || bus.cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL timeout_berr: got berr_n=%b dtack_n=%b expected 0/1", bus.cpu_berr_n, bus.cpu_dtack_n); end
    cpu_release();
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (bus.cpu_berr_n === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL timeout_release: got berr_n=%b expected 1", bus.cpu_berr_n); end
    tick(); tick();
  endtask

  task automatic test_unmapped();
    int strobes;
    bit ok;
    strobes = 0;
    cpu_drive(24'hFF0500, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick(); tick();
    if (bus.dev_uds !== 4'b0000 || bus.dev_lds !== 4'b0000) strobes++;
    checks++; if (bus.cpu_berr_n !== 1'b1) begin errors++; $display("FAIL unmapped_c0: got berr_n=%b expected 1", bus.cpu_berr_n); end
    tick(); // c1
    if (bus.dev_uds !== 4'b0000 || bus.dev_lds !== 4'b0000) strobes++;
    checks++; if (bus.cpu_berr_n !== 1'b0 || bus.cpu_dtack_n !== 1'b1) begin errors++; $display("FAIL unmapped_berr_c1: got berr_n=%b dtack_n=%b expected 0/1", bus.cpu_berr_n, bus.cpu_dtack_n); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.dev_uds !== 4'b0000 || bus.dev_lds !== 4'b0000) strobes++;
    end
    cpu_release();
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (bus.dev_uds !== 4'b0000 || bus.dev_lds !== 4'b0000) strobes++;
      if (bus.cpu_berr_n === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok || strobes != 0) begin errors++; $display("FAIL unmapped_release: got released=%b strobe_cycles=%0d expected 1/0", ok, strobes); end
    tick(); tick();
  endtask

  task automatic test_outside();
    int bad;
    bad = 0;
    cpu_drive(24'h120000, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.dev_uds !== 4'b0000 || bus.dev_lds !== 4'b0000 ||
          bus.cpu_dtack_n !== 1'b1 || bus.cpu_berr_n !== 1'b1) bad++;
    end
    cpu_release();
    tick(); tick(); tick();
    checks++; if (bad != 0) begin errors++; $display("FAIL outside_window: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bit ok;
    cpu_drive(24'hFF0100, 1'b0, 1'b0, 1'b0, 16'h5A5A);
    tick(); tick(); tick(); // c1
    checks++; if (bus.dev_uds !== 4'b0010) begin errors++; $display("FAIL rstmid_strobe: got %b expected 0010", bus.dev_uds); end
    tick(); // c2 (WAIT)
    reset = 1'b1;
    cpu_release();
    tick();
    reset = 1'b0;
    bus.dev_ack = 1'b1;
    bus.dev_data_read = 16'hFFFF;
    checks++; if (bus.cpu_dtack_n !== 1'b1 || bus.cpu_berr_n !== 1'b1 || bus.cpu_data_in !== 16'h0000) begin errors++; $display("FAIL rstmid_cpu: got dtack_n=%b berr_n=%b data=%h expected 1/1/0000", bus.cpu_dtack_n, bus.cpu_berr_n, bus.cpu_data_in); end
    checks++; if (bus.dev_rw !== 1'b1 || bus.dev_addr !== 8'h00 || bus.dev_data_write !== 16'h0000) begin errors++; $display("FAIL rstmid_dev: got rw=%b addr=%h data=%h expected 1/00/0000", bus.dev_rw, bus.dev_addr, bus.dev_data_write); end
    tick();
    bus.dev_ack = 1'b0;
    bus.dev_data_read = 16'h0000;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.cpu_dtack_n !== 1'b1 || bus.cpu_berr_n !== 1'b1 ||
          bus.dev_uds !== 4'b0000 || bus.dev_lds !== 4'b0000) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad); end
    // Clean transfer afterwards: word read, slot 3, offset 0x42
    cpu_drive(24'hFF0342, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick(); tick(); tick(); // c1
    checks++; if (bus.dev_uds !== 4'b1000 || bus.dev_lds !== 4'b1000 || bus.dev_addr !== 8'h42) begin errors++; $display("FAIL post_strobe: got uds=%b lds=%b addr=%h expected 1000/1000/42", bus.dev_uds, bus.dev_lds, bus.dev_addr); end
    tick(); // c2
    bus.dev_ack = 1'b1;
    bus.dev_data_read = 16'h1234;
    tick(); // c3
    bus.dev_ack = 1'b0;
    bus.dev_data_read = 16'h0000;
    checks++; if (bus.cpu_dtack_n !== 1'b0 || bus.cpu_data_in !== 16'h1234) begin errors++; $display("FAIL post_dtack: got dtack_n=%b data=%h expected 0/1234", bus.cpu_dtack_n, bus.cpu_data_in); end
    cpu_release();
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (bus.cpu_dtack_n === 1'b1) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL post_release: got dtack_n=%b expected 1", bus.cpu_dtack_n); end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_read();
    test_timeout();
    test_unmapped();
    test_outside();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m68k_periph_bridge.md
Name: m68k_periph_bridge

Overview:
- Bridges the asynchronous 68000 CPU bus (AS/UDS/LDS/DTACK) onto the simple synchronous peripheral bus used by the on-chip devices (LED register, etc.).
- Decodes a peripheral window, drives one-cycle per-device byte strobes and collects the device ack.
- Returns read data and generates DTACK, or BERR on timeout or an unmapped device slot.
- Sits directly upstream of every peripheral device.

Parameters:
- NDEV, 4, number of device slots; slot index = cpu_addr[11:8], must be 1..16.
- BASE, 8'hFF, peripheral window, matched against cpu_addr[23:16].
- TIMEOUT, 16, maximum cycles spent waiting for dev_ack before BERR; must be >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_as_n  in  1  68000 address strobe, asynchronous.
- cpu_uds_n  in  1  68000 upper data strobe, asynchronous.
- cpu_lds_n  in  1  68000 lower data strobe, asynchronous.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  23  68000 A[23:1].
- cpu_data_out  in  16  write data from CPU.
- cpu_data_in  out  16  read data to CPU, registered.
- cpu_dtack_n  out  1  data transfer acknowledge, active-low.
- cpu_berr_n  out  1  bus error, active-low.
- dev_addr  out  8  byte offset {cpu_addr[7:1],1'b0}.
- dev_data_write  out  16  latched write data.
- dev_rw  out  1  latched rw.
- dev_uds  out  NDEV  per-slot upper byte strobe.
- dev_lds  out  NDEV  per-slot lower byte strobe.
- dev_ack  in  1  OR of all device acks.
- dev_data_read  in  16  OR of all device read buses; idle devices drive 0.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Synchronisers: cpu_as_n, cpu_uds_n and cpu_lds_n each pass through a 2-FF synchroniser (as_s, uds_s, lds_s). Address, rw and data are stable while AS is low; they are sampled directly at the decode cycle.
- Reset:
  - State goes to IDLE; synchroniser FFs go to 1 (negated).
  - cpu_dtack_n=1, cpu_berr_n=1, cpu_data_in=0.
  - dev_uds=0, dev_lds=0, dev_rw=1, dev_addr=0, dev_data_write=0.
  - Reset mid-transfer aborts it immediately with no DTACK and no BERR. Reset wins over every other event.
- FSM states: IDLE, STROBE, WAIT, DONE, ERR, RELEASE.
- IDLE, when as_s=0 and (uds_s=0 or lds_s=0) and cpu_addr[23:16]==BASE (cycle c0):
  - Latch addr, rw, data, and the byte enables (~uds_s, ~lds_s).
  - If slot >= NDEV, go to ERR; otherwise go to STROBE.
  - Addresses outside BASE are ignored: stay in IDLE and drive nothing.
- STROBE (c1):
  - dev_uds[slot] and dev_lds[slot] follow the latched byte enables for exactly this one cycle; all other slot bits are 0.
  - dev_addr, dev_rw and dev_data_write are valid from c1 and held until the FSM returns to IDLE.
  - Clear the timeout counter, then go to WAIT.
- WAIT: all strobes are 0.
  - If dev_ack=1: cpu_data_in <= dev_data_read when dev_rw=1, else unchanged; go to DONE.
  - If the counter reaches TIMEOUT-1 with no ack: go to ERR.
  - An ack arriving in the same cycle as the timeout takes priority over the timeout.
- dev_ack is ignored in every state except WAIT.
- DONE: cpu_dtack_n=0; cpu_data_in is held. When as_s=1, go to RELEASE.
- ERR: cpu_berr_n=0, cpu_dtack_n=1. When as_s=1, go to RELEASE.
- RELEASE: cpu_dtack_n=1, cpu_berr_n=1, then go to IDLE. This guarantees at least one idle cycle between bus cycles.
- Latency: a device that acks one cycle after its strobe gives DTACK at c3. In general, a device acking in WAIT cycle k gives DTACK at c2+k+1.
- If AS negates before a response, the FSM still completes STROBE/WAIT, and DONE/ERR then falls straight through to RELEASE. No stuck state results.
- Timeout counter width is clog2(TIMEOUT). It saturates and never wraps.
- Read-modify-write (AS held low across two DS cycles) is not supported. After RELEASE, the FSM re-arms only on a fresh AS assertion, tracked by an as_seen_high flag set when as_s=1.

Test Plan:
- Word write 0xA5xx to BASE:0x0100 (slot 1, uds+lds); device acks 1 cycle after strobe -> dev_uds=4'b0010 and dev_lds=4'b0010 for one cycle, dev_data_write=0xA5xx, dev_rw=0, cpu_dtack_n low at c3, released one cycle after as_s rises.
- Byte read, uds only, at slot 0 offset 0x00; device returns 0x3C00 with ack -> cpu_data_in=0x3C00 while dtack_n=0; dev_lds=0 throughout.
- Access to slot 2 where no device acks, TIMEOUT=16 -> cpu_berr_n=0 at c2+16, cpu_dtack_n stays 1; cpu_berr_n returns to 1 after AS negates.
- Access to slot 5 with NDEV=4 -> ERR directly from c0, no strobe pulses at all, cpu_berr_n=0 at c1.
- Address 0x120000 (outside BASE) -> FSM stays IDLE, all dev_* strobes 0, dtack_n=1 and berr_n=1 throughout.
- Assert reset during WAIT; assert dev_ack on the following cycle -> outputs return to reset values with no DTACK; the next clean transfer completes normally.
